// File: rtl/keypad_pkg.sv
// keypad_pkg: scanner state type, one-cold column strobes and strobe lookup.
package keypad_pkg;

    typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} state_t;

    localparam logic [3:0] COL0 = 4'b1110;
    localparam logic [3:0] COL1 = 4'b1101;
    localparam logic [3:0] COL2 = 4'b1011;
    localparam logic [3:0] COL3 = 4'b0111;

    function automatic logic [3:0] col_strobe(input logic [1:0] idx);
        return idx == 2'd0 ? COL0 : idx == 2'd1 ? COL1 : idx == 2'd2 ? COL2 : COL3;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for asynchronous inputs; idles high after reset.
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta <= '1;
            q    <= '1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 matrix scanner with tick-based press/release debounce.
// key_code = row*4 + col of the last accepted key; key_valid pulses once per press.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_RATE      = 19,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] rows,
    output logic [3:0] cols,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_down
);

    localparam logic [3:0] DS = 4'(DEBOUNCE_SCANS);

    logic [3:0]  rows_s;
    logic [24:0] scan_cnt;
    logic [24:0] scan_nxt;
    logic        tick;
    logic        single;
    logic        all_high;
    logic [1:0]  low_row;
    logic [1:0]  col_idx;
    logic [1:0]  nxt_col;
    logic [1:0]  row_idx;
    logic [3:0]  count;
    state_t      state;

    sync_2ff #(.WIDTH(4)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (rows),
        .q     (rows_s)
    );

    // The tick fires on the clock where bit SCAN_RATE would set; clearing it restarts the period.
    assign scan_nxt = scan_cnt + 25'd1;
    assign tick     = scan_nxt[SCAN_RATE];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) scan_cnt <= '0;
        else       scan_cnt <= tick ? scan_nxt & ~(25'd1 << SCAN_RATE) : scan_nxt;
    end

    // A single low row reads the same as a one-cold strobe pattern.
    assign single   = rows_s inside {COL0, COL1, COL2, COL3};
    assign all_high = rows_s == 4'hF;
    assign low_row  = rows_s == COL0 ? 2'd0 : rows_s == COL1 ? 2'd1 : rows_s == COL2 ? 2'd2 : 2'd3;
    assign nxt_col  = col_idx + 2'd1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= SCAN;
            cols      <= COL0;
            col_idx   <= 2'd0;
            row_idx   <= 2'd0;
            count     <= 4'd0;
            key_code  <= 4'd0;
            key_valid <= 1'b0;
            key_down  <= 1'b0;
        end else begin
            key_valid <= 1'b0;
            unique case (state)
                SCAN: if (tick) begin
                    if (single) begin
                        row_idx <= low_row;
                        count   <= 4'd0;
                        state   <= DEBOUNCE;
                    end else begin
                        col_idx <= nxt_col;
                        cols    <= col_strobe(nxt_col);
                    end
                end
                DEBOUNCE: if (count == DS) begin
                    key_code  <= {row_idx, col_idx};
                    key_valid <= 1'b1;
                    key_down  <= 1'b1;
                    state     <= HELD;
                end else if (tick) begin
                    if (rows_s == col_strobe(row_idx)) begin
                        count <= count + 4'd1;
                    end else begin
                        col_idx <= nxt_col;
                        cols    <= col_strobe(nxt_col);
                        state   <= SCAN;
                    end
                end
                HELD: if (tick && all_high) begin
                    count <= 4'd0;
                    state <= RELEASE;
                end
                RELEASE: if (count == DS) begin
                    key_down <= 1'b0;
                    col_idx  <= nxt_col;
                    cols     <= col_strobe(nxt_col);
                    state    <= SCAN;
                end else if (tick) begin
                    if (all_high) count <= count + 4'd1;
                    else          state <= HELD;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: simulated key matrix plus a tick-level reference model.
module tb_keypad_scanner;

    localparam int DS = 3;
    localparam int IDLE = 0, ARMING = 1, HOLDING = 2, LEAVING = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  rows;
    logic [3:0]  cols;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_down;
    logic [15:0] pressed = '0;
    int          checks = 0;
    int          errs = 0;

    keypad_scanner #(.SCAN_RATE(2), .DEBOUNCE_SCANS(DS)) dut (
        .clk       (clk),
        .reset     (reset),
        .rows      (rows),
        .cols      (cols),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_down  (key_down)
    );

    always #5 clk = ~clk;

    // Pressed key (r,c) pulls row r low while column c is strobed.
    always_comb for (int r = 0; r < 4; r++) rows[r] = ~|(pressed[r*4 +: 4] & ~cols);

    // Reference: one decision per scan tick (every 4th clock), acceptance one clock after the deciding tick.
    int         n, mcol, phase, cnt, mrow, nl, lr;
    logic [3:0] ecols, ecode;
    logic       edown, evalid;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            n = 0; mcol = 0; phase = IDLE; cnt = 0; mrow = 0;
            ecode = 4'd0; edown = 1'b0; evalid = 1'b0;
        end else begin
            evalid = 1'b0;
            if (phase == ARMING && cnt == DS) begin
                evalid = 1'b1; edown = 1'b1; ecode = 4'(mrow * 4 + mcol); phase = HOLDING;
            end else if (phase == LEAVING && cnt == DS) begin
                edown = 1'b0; phase = IDLE; mcol = (mcol + 1) % 4;
            end else if (n % 4 == 3) begin
                nl = 0; lr = 0;
                for (int r = 0; r < 4; r++) if (pressed[r*4 + mcol]) begin nl++; lr = r; end
                case (phase)
                    IDLE:    if (nl == 1) begin phase = ARMING; mrow = lr; cnt = 0; end
                             else mcol = (mcol + 1) % 4;
                    ARMING:  if (nl == 1 && lr == mrow) cnt++;
                             else begin phase = IDLE; mcol = (mcol + 1) % 4; end
                    HOLDING: if (nl == 0) begin phase = LEAVING; cnt = 0; end
                    default: if (nl == 0) cnt++; else phase = HOLDING;
                endcase
            end
            n++;
        end
        ecols = 4'hF ^ (4'h1 << mcol);
    end

    task automatic apply_reset();
        pressed = '0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({cols, key_valid, key_down, key_code} !== {4'b1110, 1'b0, 1'b0, 4'd0}) begin
            errs++;
            $display("FAIL reset_async got %b/%b/%b/%0d want 1110/0/0/0", cols, key_valid, key_down, key_code);
        end
        repeat (2) @(negedge clk);
        checks++;
        if ({cols, key_valid, key_down, key_code} !== {4'b1110, 1'b0, 1'b0, 4'd0}) begin
            errs++;
            $display("FAIL reset_hold got %b/%b/%b/%0d want 1110/0/0/0", cols, key_valid, key_down, key_code);
        end
        reset = 1'b0;
    endtask

    task automatic test_idle();
        int pulses = 0, changes = 0;
        logic [3:0] prev;
        apply_reset();
        prev = cols;
        repeat (32) begin
            @(negedge clk);
            checks++;
            if ({cols, key_valid, key_down, key_code} !== {ecols, evalid, edown, ecode}) begin
                errs++;
                $display("FAIL idle t=%0t got %b/%b/%b/%0d want %b/%b/%b/%0d", $time, cols, key_valid, key_down, key_code, ecols, evalid, edown, ecode);
            end
            pulses += int'(key_valid);
            changes += int'(cols != prev);
            prev = cols;
        end
        checks++;
        if (pulses != 0 || changes != 8) begin
            errs++;
            $display("FAIL idle_summary got pulses=%0d changes=%0d want 0/8", pulses, changes);
        end
    endtask

    task automatic test_press();
        int pulses = 0;
        apply_reset();
        pressed[9] = 1'b1;
        repeat (24) begin
            @(negedge clk);
            checks++;
            if ({cols, key_valid, key_down, key_code} !== {ecols, evalid, edown, ecode}) begin
                errs++;
                $display("FAIL press t=%0t got %b/%b/%b/%0d want %b/%b/%b/%0d", $time, cols, key_valid, key_down, key_code, ecols, evalid, edown, ecode);
            end
            pulses += int'(key_valid);
        end
        checks++;
        if ({pulses[3:0], cols, key_down, key_code} !== {4'd1, 4'b1101, 1'b1, 4'd9}) begin
            errs++;
            $display("FAIL press_result got pulses=%0d cols=%b down=%b code=%0d want 1/1101/1/9", pulses, cols, key_down, key_code);
        end
    endtask

    task automatic test_short_press();
        int pulses = 0;
        apply_reset();
        for (int s = 0; s < 3; s++) begin
            pressed = (s == 0) ? 16'h0200 : 16'h0000;
            repeat ((s == 0) ? 12 : (s == 1) ? 4 : 16) begin
                @(negedge clk);
                checks++;
                if ({cols, key_valid, key_down, key_code} !== {ecols, evalid, edown, ecode}) begin
                    errs++;
                    $display("FAIL short t=%0t got %b/%b/%b/%0d want %b/%b/%b/%0d", $time, cols, key_valid, key_down, key_code, ecols, evalid, edown, ecode);
                end
                pulses += int'(key_valid);
            end
            if (s == 1) begin
                checks++;
                if (cols !== 4'b1011) begin
                    errs++;
                    $display("FAIL short_resume got cols=%b want 1011", cols);
                end
            end
        end
        checks++;
        if (pulses != 0) begin
            errs++;
            $display("FAIL short_no_valid got %0d pulses want 0", pulses);
        end
    endtask

    task automatic test_bounce();
        int pulses = 0;
        int len[4] = '{6, 1, 2, 5};
        apply_reset();
        for (int s = 0; s < 4; s++) begin
            pressed = (s % 2 == 0) ? 16'h0200 : 16'h0000;
            repeat (len[s] * 4) begin
                @(negedge clk);
                checks++;
                if ({cols, key_valid, key_down, key_code} !== {ecols, evalid, edown, ecode}) begin
                    errs++;
                    $display("FAIL bounce t=%0t got %b/%b/%b/%0d want %b/%b/%b/%0d", $time, cols, key_valid, key_down, key_code, ecols, evalid, edown, ecode);
                end
                pulses += int'(key_valid);
            end
            if (s == 1 || s == 2) begin
                checks++;
                if (key_down !== 1'b1 || pulses != 1) begin
                    errs++;
                    $display("FAIL bounce_held got down=%b pulses=%0d want 1/1", key_down, pulses);
                end
            end
        end
        checks++;
        if (key_down !== 1'b0 || pulses != 1) begin
            errs++;
            $display("FAIL bounce_release got down=%b pulses=%0d want 0/1", key_down, pulses);
        end
    endtask

    task automatic test_two_rows();
        int pulses = 0, changes = 0;
        logic [3:0] prev;
        apply_reset();
        pressed = 16'h1001;
        prev = cols;
        repeat (48) begin
            @(negedge clk);
            checks++;
            if ({cols, key_valid, key_down, key_code} !== {ecols, evalid, edown, ecode}) begin
                errs++;
                $display("FAIL two_rows t=%0t got %b/%b/%b/%0d want %b/%b/%b/%0d", $time, cols, key_valid, key_down, key_code, ecols, evalid, edown, ecode);
            end
            pulses += int'(key_valid);
            changes += int'(cols != prev);
            prev = cols;
        end
        checks++;
        if (pulses != 0 || changes != 12) begin
            errs++;
            $display("FAIL two_rows_summary got pulses=%0d changes=%0d want 0/12", pulses, changes);
        end
    endtask

    task automatic test_reset_mid_debounce();
        int len[3] = '{7, 6, 2};
        logic [15:0] pat[3] = '{16'h0040, 16'h0000, 16'h0020};
        apply_reset();
        for (int s = 0; s < 3; s++) begin
            pressed = pat[s];
            repeat (len[s] * 4) begin
                @(negedge clk);
                checks++;
                if ({cols, key_valid, key_down, key_code} !== {ecols, evalid, edown, ecode}) begin
                    errs++;
                    $display("FAIL mid_debounce t=%0t got %b/%b/%b/%0d want %b/%b/%b/%0d", $time, cols, key_valid, key_down, key_code, ecols, evalid, edown, ecode);
                end
            end
        end
        checks++;
        if (cols !== 4'b1101 || key_code !== 4'd6) begin
            errs++;
            $display("FAIL mid_debounce_pre got cols=%b code=%0d want 1101/6", cols, key_code);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({cols, key_valid, key_down, key_code} !== {4'b1110, 1'b0, 1'b0, 4'd0}) begin
            errs++;
            $display("FAIL mid_debounce_reset got %b/%b/%b/%0d want 1110/0/0/0", cols, key_valid, key_down, key_code);
        end
        pressed = '0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_random();
        apply_reset();
        for (int it = 0; it < 24; it++) begin
            if (it % 2 == 0) begin
                pressed = 16'h0001 << $urandom_range(0, 15);
                if ($urandom_range(0, 3) == 0) pressed |= 16'h0001 << $urandom_range(0, 15);
            end else begin
                pressed = '0;
            end
            repeat ($urandom_range(1, 9) * 4) begin
                @(negedge clk);
                checks++;
                if ({cols, key_valid, key_down, key_code} !== {ecols, evalid, edown, ecode}) begin
                    errs++;
                    $display("FAIL random t=%0t keys=%h got %b/%b/%b/%0d want %b/%b/%b/%0d", $time, pressed, cols, key_valid, key_down, key_code, ecols, evalid, edown, ecode);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_idle();
        test_press();
        test_short_press();
        test_bounce();
        test_two_rows();
        test_reset_mid_debounce();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errs);
        $finish;
    end

endmodule
